// File: rtl/mem_arbiter_if.sv
// Memory-port handshake bundles shared by the arbiter and its requesters.
// val/addr(/wen/wdata) flow master->slave; rdata/rdy flow slave->master.
interface mem_rwport;
    logic        val;
    logic        wen;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;

    modport master (output val, output wen, output addr, output wdata,
                    input rdata, input rdy);
    modport slave  (input val, input wen, input addr, input wdata,
                    output rdata, output rdy);
endinterface

interface mem_rport;
    logic        val;
    logic [7:0]  addr;
    logic [15:0] rdata;
    logic        rdy;

    modport master (output val, output addr, input rdata, input rdy);
    modport slave  (input val, input addr, output rdata, output rdy);
endinterface

// File: rtl/mem_arbiter.sv
// Three-way arbiter onto one 256x16 memory port: panel has absolute priority,
// CPU data and instruction fetch share round-robin; stalled accesses time out.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    mem_rwport.slave   pnl,
    mem_rwport.slave   dat,
    mem_rport.slave    ifu,
    mem_rwport.master  mem,
    output logic       err,
    input  logic       err_clr
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {G_PNL, G_DAT, G_IFU} grant_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    grant_t      grant_reg;
    logic        last_dat_reg;
    logic [7:0]  cnt_reg;
    logic [7:0]  addr_reg;
    logic        wen_reg;
    logic [15:0] wdata_reg;
    logic        err_reg;

    logic        busy;
    logic        done;
    logic        expire;
    logic        finish;
    logic        any_req;
    grant_t      win;
    logic [15:0] resp;

    assign busy    = (state_reg == BUSY);
    assign done    = busy && mem.rdy;
    assign expire  = busy && !mem.rdy && (cnt_reg == CNT_LAST);
    // An access cut short by reset never reports completion.
    assign finish  = (done || expire) && !rst;
    assign any_req = pnl.val || dat.val || ifu.val;

    always_comb begin
        win = G_IFU;
        if (pnl.val)
            win = G_PNL;
        else if (dat.val && ifu.val)
            win = last_dat_reg ? G_IFU : G_DAT;
        else if (dat.val)
            win = G_DAT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= G_PNL;
            last_dat_reg <= 1'b0;
            cnt_reg      <= 8'd0;
            addr_reg     <= 8'd0;
            wen_reg      <= 1'b0;
            wdata_reg    <= 16'd0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg <= BUSY;
                        grant_reg <= win;
                        cnt_reg   <= 8'd0;
                        case (win)
                            G_PNL: begin
                                addr_reg  <= pnl.addr;
                                wen_reg   <= pnl.wen;
                                wdata_reg <= pnl.wdata;
                            end
                            G_DAT: begin
                                addr_reg     <= dat.addr;
                                wen_reg      <= dat.wen;
                                wdata_reg    <= dat.wdata;
                                last_dat_reg <= 1'b1;
                            end
                            default: begin
                                addr_reg     <= ifu.addr;
                                wen_reg      <= 1'b0;
                                wdata_reg    <= 16'd0;
                                last_dat_reg <= 1'b0;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    if (done || expire)
                        state_reg <= IDLE;
                    else
                        cnt_reg <= cnt_reg + 8'd1;
                end
                default: state_reg <= IDLE;
            endcase

            // A timeout in the same cycle as a clear request keeps the flag set.
            if (expire)
                err_reg <= 1'b1;
            else if (err_clr)
                err_reg <= 1'b0;
        end
    end

    assign mem.val   = busy;
    assign mem.wen   = busy && wen_reg;
    assign mem.addr  = addr_reg;
    assign mem.wdata = wdata_reg;

    assign resp      = expire ? 16'h0000 : mem.rdata;
    assign pnl.rdata = resp;
    assign dat.rdata = resp;
    assign ifu.rdata = resp;

    assign pnl.rdy = finish && (grant_reg == G_PNL);
    assign dat.rdy = finish && (grant_reg == G_DAT);
    assign ifu.rdy = finish && (grant_reg == G_IFU);

    assign err = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle table for the documented scenarios, then randomized traffic
// against a transaction-level model with a behavioural 256x16 memory.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic clk;
    logic rst;
    logic err;
    logic err_clr;

    mem_rwport pnl_if ();
    mem_rwport dat_if ();
    mem_rport  ifu_if ();
    mem_rwport mem_if ();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .pnl     (pnl_if.slave),
        .dat     (dat_if.slave),
        .ifu     (ifu_if.slave),
        .mem     (mem_if.master),
        .err     (err),
        .err_clr (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        pv, pw;
        logic [7:0]  pa;
        logic [15:0] pd;
        logic        dv, dw;
        logic [7:0]  da;
        logic [15:0] dd;
        logic        iv;
        logic [7:0]  ia;
        logic        mr;
        logic [15:0] md;
        logic        ec;
        logic        e_mval;
        logic [7:0]  e_maddr;
        logic        e_mwen;
        logic [15:0] e_mwd;
        logic [2:0]  e_rdy;    // {pnl, dat, ifu}
        logic [15:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic pv, input logic pw, input logic [7:0] pa, input logic [15:0] pd,
        input logic dv, input logic dw, input logic [7:0] da, input logic [15:0] dd,
        input logic iv, input logic [7:0] ia, input logic mr, input logic [15:0] md, input logic ec,
        input logic emv, input logic [7:0] ema, input logic emw, input logic [15:0] emd,
        input logic [2:0] erdy, input logic [15:0] erd, input logic eerr);
        vec_t v;
        v.rst = r; v.pv = pv; v.pw = pw; v.pa = pa; v.pd = pd;
        v.dv = dv; v.dw = dw; v.da = da; v.dd = dd; v.iv = iv; v.ia = ia;
        v.mr = mr; v.md = md; v.ec = ec;
        v.e_mval = emv; v.e_maddr = ema; v.e_mwen = emw; v.e_mwd = emd;
        v.e_rdy = erdy; v.e_rdata = erd; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic pv, input logic pw, input logic [7:0] pa,
                         input logic [15:0] pd, input logic dv, input logic dw, input logic [7:0] da,
                         input logic [15:0] dd, input logic iv, input logic [7:0] ia,
                         input logic mr, input logic [15:0] md, input logic ec);
        rst = r;
        pnl_if.val = pv; pnl_if.wen = pw; pnl_if.addr = pa; pnl_if.wdata = pd;
        dat_if.val = dv; dat_if.wen = dw; dat_if.addr = da; dat_if.wdata = dd;
        ifu_if.val = iv; ifu_if.addr = ia;
        mem_if.rdy = mr; mem_if.rdata = md;
        err_clr = ec;
    endtask

    // Randomized-phase state: requester pending transactions and reference model
    logic        pend [3];
    logic        p_wen [3];
    logic [7:0]  p_addr [3];
    logic [15:0] p_wd [3];
    logic [15:0] ref_mem [256];
    int          m_cur;
    int          m_age;
    logic        m_last_dat;
    logic        m_err;
    logic [7:0]  m_addr;
    logic        m_wen;
    logic [15:0] m_wd;

    initial begin
        vec_t v;
        logic [2:0]  got_rdy;
        logic [2:0]  exp_rdy;
        logic [15:0] got_rd;
        logic        mr;
        logic        ec;
        logic        fin;
        logic        tmo;
        int          w;

        drive(1, 0,0,8'h00,16'h0, 0,0,8'h00,16'h0, 0,8'h00, 0,16'h0, 0);
        @(posedge clk); @(posedge clk); #1;

        // Reset, single read, dat/ifu alternation, held val
        tbl.push_back(mk(1, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 0,16'h0000,0, 0,8'h00,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h10,16'h0,    0,8'h00, 0,16'h0000,0, 0,8'h00,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h10,16'h0,    0,8'h00, 0,16'h0000,0, 1,8'h10,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h10,16'h0,    0,8'h00, 1,16'hBEEF,0, 1,8'h10,0,16'h0000, 3'b010,16'hBEEF,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 0,16'h0000,0, 0,8'h10,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h20,16'h0,    1,8'h30, 0,16'h0000,0, 0,8'h10,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h20,16'h0,    1,8'h30, 1,16'h1111,0, 1,8'h30,0,16'h0000, 3'b001,16'h1111,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h20,16'h0,    1,8'h30, 0,16'h0000,0, 0,8'h30,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h20,16'h0,    1,8'h30, 1,16'h2222,0, 1,8'h20,0,16'h0000, 3'b010,16'h2222,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h30, 0,16'h0000,0, 0,8'h20,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h30, 1,16'h3333,0, 1,8'h30,0,16'h0000, 3'b001,16'h3333,0));
        // Panel arrives while ifu is busy; pointer untouched by the panel grant
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h31, 0,16'h0000,0, 0,8'h30,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 1,1,8'hFF,16'h1234, 1,1,8'h22,16'h5555, 1,8'h31, 0,16'h0000,0, 1,8'h31,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 1,1,8'hFF,16'h1234, 1,1,8'h22,16'h5555, 1,8'h31, 1,16'h4444,0, 1,8'h31,0,16'h0000, 3'b001,16'h4444,0));
        tbl.push_back(mk(0, 1,1,8'hFF,16'h1234, 1,1,8'h22,16'h5555, 0,8'h00, 0,16'h0000,0, 0,8'h31,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 1,1,8'hFF,16'h1234, 1,1,8'h22,16'h5555, 0,8'h00, 1,16'h0000,0, 1,8'hFF,1,16'h1234, 3'b100,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,1,8'h22,16'h5555, 1,8'h32, 0,16'h0000,0, 0,8'hFF,0,16'h1234, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,1,8'h22,16'h5555, 1,8'h32, 1,16'h0000,0, 1,8'h22,1,16'h5555, 3'b010,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h32, 0,16'h0000,0, 0,8'h22,0,16'h5555, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h32, 1,16'h6666,0, 1,8'h32,0,16'h0000, 3'b001,16'h6666,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h33, 0,16'h0000,0, 0,8'h32,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h33, 1,16'h7777,0, 1,8'h33,0,16'h0000, 3'b001,16'h7777,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h33, 0,16'h0000,0, 0,8'h33,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h33, 1,16'h7778,0, 1,8'h33,0,16'h0000, 3'b001,16'h7778,0));
        // Timeout on the 4th busy cycle, ignored idle rdy, err_clr vs. timeout
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h40,16'h0,    0,8'h00, 0,16'h0000,0, 0,8'h33,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h40,16'h0,    0,8'h00, 0,16'h0000,0, 1,8'h40,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h40,16'h0,    0,8'h00, 0,16'h0000,0, 1,8'h40,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h40,16'h0,    0,8'h00, 0,16'h0000,0, 1,8'h40,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h40,16'h0,    0,8'h00, 0,16'hABCD,0, 1,8'h40,0,16'h0000, 3'b010,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 1,16'h0001,0, 0,8'h40,0,16'h0000, 3'b000,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h50, 0,16'h0000,0, 0,8'h40,0,16'h0000, 3'b000,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h50, 0,16'h0000,0, 1,8'h50,0,16'h0000, 3'b000,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h50, 0,16'h0000,0, 1,8'h50,0,16'h0000, 3'b000,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h50, 0,16'h0000,0, 1,8'h50,0,16'h0000, 3'b000,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    1,8'h50, 0,16'h5A5A,1, 1,8'h50,0,16'h0000, 3'b001,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 0,16'h0000,0, 0,8'h50,0,16'h0000, 3'b000,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 0,16'h0000,1, 0,8'h50,0,16'h0000, 3'b000,16'h0000,1));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 0,16'h0000,0, 0,8'h50,0,16'h0000, 3'b000,16'h0000,0));
        // Reset in the second busy cycle, late mem rdy, then tie goes to dat
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h60,16'h0,    1,8'h61, 0,16'h0000,0, 0,8'h50,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h60,16'h0,    1,8'h61, 0,16'h0000,0, 1,8'h60,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(1, 0,0,8'h00,16'h0,    1,0,8'h60,16'h0,    1,8'h61, 1,16'h9999,0, 1,8'h60,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 1,16'h0001,0, 0,8'h00,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h62,16'h0,    1,8'h63, 0,16'h0000,0, 0,8'h00,0,16'h0000, 3'b000,16'h0000,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    1,0,8'h62,16'h0,    1,8'h63, 1,16'h8888,0, 1,8'h62,0,16'h0000, 3'b010,16'h8888,0));
        tbl.push_back(mk(0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0,    0,8'h00, 0,16'h0000,0, 0,8'h62,0,16'h0000, 3'b000,16'h0000,0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.rst, v.pv, v.pw, v.pa, v.pd, v.dv, v.dw, v.da, v.dd, v.iv, v.ia, v.mr, v.md, v.ec);
            #1;
            got_rdy = {pnl_if.rdy, dat_if.rdy, ifu_if.rdy};
            chk($sformatf("row%0d mem.val", i),   32'(mem_if.val),   32'(v.e_mval));
            chk($sformatf("row%0d mem.addr", i),  32'(mem_if.addr),  32'(v.e_maddr));
            chk($sformatf("row%0d mem.wen", i),   32'(mem_if.wen),   32'(v.e_mwen));
            chk($sformatf("row%0d mem.wdata", i), 32'(mem_if.wdata), 32'(v.e_mwd));
            chk($sformatf("row%0d rdy", i),       32'(got_rdy),      32'(v.e_rdy));
            chk($sformatf("row%0d err", i),       32'(err),          32'(v.e_err));
            if (v.e_rdy[2]) chk($sformatf("row%0d pnl.rdata", i), 32'(pnl_if.rdata), 32'(v.e_rdata));
            if (v.e_rdy[1]) chk($sformatf("row%0d dat.rdata", i), 32'(dat_if.rdata), 32'(v.e_rdata));
            if (v.e_rdy[0]) chk($sformatf("row%0d ifu.rdata", i), 32'(ifu_if.rdata), 32'(v.e_rdata));
            @(posedge clk); #1;
        end

        // Randomized traffic against the reference model
        for (int a = 0; a < 256; a++) ref_mem[a] = 16'($urandom);
        for (int p = 0; p < 3; p++) begin
            pend[p] = 1'b0; p_wen[p] = 1'b0; p_addr[p] = 8'h0; p_wd[p] = 16'h0;
        end
        drive(1, 0,0,8'h00,16'h0, 0,0,8'h00,16'h0, 0,8'h00, 0,16'h0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_cur = -1; m_age = 0; m_last_dat = 1'b0; m_err = 1'b0;
        m_addr = 8'h00; m_wen = 1'b0; m_wd = 16'h0000;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 3; p++) begin
                if (!pend[p] && ($urandom_range(0, (p == 0) ? 7 : 1) == 0)) begin
                    pend[p]   = 1'b1;
                    p_addr[p] = 8'($urandom_range(0, 15));
                    p_wen[p]  = (p == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                    p_wd[p]   = 16'($urandom);
                end
            end
            mr = ($urandom_range(0, 99) < 35);
            ec = ($urandom_range(0, 15) == 0);
            drive(0, pend[0], p_wen[0], p_addr[0], p_wd[0], pend[1], p_wen[1], p_addr[1], p_wd[1],
                  pend[2], p_addr[2], mr, ref_mem[mem_if.addr], ec);
            #1;

            fin = (m_cur >= 0) && (mr || (m_age == TO - 1));
            tmo = fin && !mr;
            exp_rdy = 3'b000;
            if (fin) exp_rdy[2 - m_cur] = 1'b1;
            got_rdy = {pnl_if.rdy, dat_if.rdy, ifu_if.rdy};
            chk("rnd mem.val",   32'(mem_if.val),   32'(m_cur >= 0));
            chk("rnd mem.addr",  32'(mem_if.addr),  32'(m_addr));
            chk("rnd mem.wen",   32'(mem_if.wen),   32'((m_cur >= 0) && m_wen));
            chk("rnd mem.wdata", 32'(mem_if.wdata), 32'(m_wd));
            chk("rnd rdy",       32'(got_rdy),      32'(exp_rdy));
            chk("rnd err",       32'(err),          32'(m_err));
            if (fin && (tmo || !m_wen)) begin
                got_rd = (m_cur == 0) ? pnl_if.rdata : (m_cur == 1) ? dat_if.rdata : ifu_if.rdata;
                chk("rnd rdata", 32'(got_rd), 32'(tmo ? 16'h0000 : ref_mem[m_addr]));
            end

            if (m_cur < 0) begin
                if (pend[0] || pend[1] || pend[2]) begin
                    if (pend[0])                 w = 0;
                    else if (pend[1] && pend[2]) w = m_last_dat ? 2 : 1;
                    else if (pend[1])            w = 1;
                    else                         w = 2;
                    if (w == 1) m_last_dat = 1'b1;
                    if (w == 2) m_last_dat = 1'b0;
                    m_cur  = w;
                    m_age  = 0;
                    m_addr = p_addr[w];
                    m_wen  = (w == 2) ? 1'b0 : p_wen[w];
                    m_wd   = (w == 2) ? 16'h0000 : p_wd[w];
                end
            end else if (fin) begin
                if (mr && m_wen) ref_mem[m_addr] = m_wd;
                pend[m_cur] = 1'b0;
                m_cur = -1;
            end else begin
                m_age++;
            end
            if (tmo) m_err = 1'b1;
            else if (ec) m_err = 1'b0;

            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles a granted access waits for mem.rdy before it is aborted; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: pnl  mem_rwport.slave  -  front-panel/loader requester, read/write (val, wen, addr[8], wdata[16], rdata[16], rdy).
REQ-005 Port: dat  mem_rwport.slave  -  CPU data requester, read/write.
REQ-006 Port: ifu  mem_rport.slave  -  CPU instruction-fetch requester, read only (val, addr[8], rdata[16], rdy).
REQ-007 Port: mem  mem_rwport.master  -  the single shared 256x16 memory port.
REQ-008 Port: err  output  1  sticky flag, set when an access times out.
REQ-009 Port: err_clr  input  1  clears err.

Function
REQ-010 Handshake, all ports: a master raises val with stable addr/wen/wdata and holds them until it samples rdy=1; rdy is a 1-cycle pulse; rdata is valid only in the rdy cycle.
REQ-011 States SHALL be IDLE and BUSY.
REQ-012 IDLE: if any upstream val=1, select a winner, register its addr/wen/wdata and its grant id, go to BUSY next cycle.
REQ-013 Priority: pnl wins over dat and ifu whenever pnl.val=1.
REQ-014 Between dat and ifu, with pnl idle: round-robin; when both request, the one NOT granted most recently wins; last-grant pointer resets to ifu, so dat wins the first tie.
REQ-015 An access granted to pnl SHALL NOT update the dat/ifu round-robin pointer.
REQ-016 ifu grants SHALL drive mem.wen=0 and mem.wdata=0.
REQ-017 BUSY: mem.val=1 with the registered addr/wen/wdata, held constant; upstream val changes are ignored until return to IDLE.
REQ-018 In IDLE: mem.val=0, mem.wen=0; mem.addr and mem.wdata hold their last values.
REQ-019 Completion: in a BUSY cycle with mem.rdy=1, the granted port's rdy=1 in that same cycle (combinational); next state IDLE.
REQ-020 rdata: mem.rdata is routed to all three upstream rdata outputs; only the granted port sees rdy.
REQ-021 Non-granted ports SHALL keep rdy=0 at all times.
REQ-022 Latency: request visible in IDLE cycle N gives mem.val=1 from cycle N+1; with a zero-wait memory, upstream rdy in cycle N+1. Max throughput: one access per 2 cycles.
REQ-023 A requester that keeps val=1 after its rdy pulse is treated as a new request in the following IDLE cycle.
REQ-024 Timeout: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle without mem.rdy. At count TIMEOUT-1 without rdy, the block returns to IDLE, pulses the granted port's rdy once with rdata = 16'h0000, and sets err.
REQ-025 err_clr=1 clears err; if a timeout occurs in the same cycle, err SHALL stay set (set wins).
REQ-026 mem.rdy arriving in IDLE SHALL be ignored.

Reset
REQ-027 rst=1 at any clock edge, including mid-access: state=IDLE, round-robin pointer=ifu, timeout counter=0, err=0, mem.val=0, mem.wen=0, mem.addr=0, mem.wdata=0.
REQ-028 During and after reset, all upstream rdy=0 until a new grant completes; an aborted access is not completed or retried.

Verification
REQ-029 Single read: dat.val=1, wen=0, addr=8'h10; memory returns 16'hBEEF with rdy one cycle after mem.val -> mem.addr=8'h10 next cycle; dat.rdy=1 with rdata=16'hBEEF two cycles after the request.
REQ-030 Contention: dat and ifu both request continuously -> grants alternate dat, ifu, dat, ifu; mem.val shows 0 for one cycle between accesses.
REQ-031 Panel priority: pnl write addr=8'hFF, wdata=16'h1234 arrives while ifu is BUSY -> ifu completes first, then pnl is granted ahead of a pending dat; the next dat/ifu tie follows the unchanged pointer.
REQ-032 Timeout: TIMEOUT=4, memory never asserts rdy -> granted rdy pulses with rdata=0 on the 4th BUSY cycle and err=1; err_clr=1 on the same cycle as a second timeout leaves err=1.
REQ-033 Reset mid-access: rst=1 in the second BUSY cycle -> next cycle mem.val=0, all rdy=0, err=0; a late mem.rdy is ignored; the next dat/ifu tie is granted to dat.
REQ-034 Held val: ifu holds val=1 for 3 accesses while dat is idle -> three grants to ifu, each separated by one IDLE cycle.
